mpei_spi_slave_regif: RTL and testbench
=======================================

Name: mpei_spi_slave_regif

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) slave responder that lets an external SPI master (e.g. the core's SPI controller in loopback, or a host) read and write a small bank of 8-bit registers.
- SCK, MOSI and CSn are asynchronous to clk_i. They are oversampled by clk_i through 2-flop synchronizers and edge-detected.
- Register contents go to local logic as a flat vector, plus a one-cycle write strobe.

Parameters:
NREGS    8      number of 8-bit registers, 2..128; address range 0..NREGS-1
ID_VAL   8'hA5  read-only value of register 0

Ports:
clk_i          in   1          system clock; must be >= 8x SCK frequency
rstn_i         in   1          asynchronous active-low reset
spi_sck_i      in   1          SPI clock from master, asynchronous
spi_mosi_i     in   1          master-out data, asynchronous
spi_csn_i      in   1          chip select, active-low, asynchronous
spi_miso_o     out  1          slave-out data
spi_misooen_o  out  1          MISO output enable, active-low (1 = hi-Z)
regs_o         out  NREGS*8    register bank, reg[i] at bits [8i+7:8i]
wr_stb_o       out  1          one-cycle pulse on committed SPI write
wr_addr_o      out  7          address of last committed write
wr_data_o      out  8          data of last committed write
frame_err_o    out  1          one-cycle pulse on aborted frame or invalid address
busy_o         out  1          1 while the synchronized CSn is low

Behaviour:
- Reset (asynchronous, rstn_i=0) sets:
  - regs: reg0=ID_VAL, all others 0
  - spi_miso_o=0, spi_misooen_o=1, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, frame_err_o=0, busy_o=0
  - FSM=IDLE, bit counter=0
- Synchronizers: 2 flops each on sck, mosi, csn; the csn synchronizer resets to 1.
  - sck_rise = sck_s & ~sck_q; sck_fall = ~sck_s & sck_q.
  - Pin-to-internal latency is 3 clk_i cycles.
- Frame format: 16 bits, MSB first.
  - bit15 = RW (1 = write, 0 = read)
  - bits14:8 = address
  - bits7:0 = data
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE: csn_s falls -> CMD; counter=0; busy_o=1; spi_misooen_o=0; spi_miso_o=0.
  - CMD: on each sck_rise, shift mosi_s into rx_sr and increment the counter. On the 8th rise, latch RW and address, load tx_sr with reg[addr] (0x00 if addr >= NREGS), then -> DATA.
  - DATA, MISO: on each sck_fall, spi_miso_o = tx_sr[7] and tx_sr shifts left, so the first data bit is valid before the 9th rising edge. While in CMD, spi_miso_o stays 0.
  - DATA, MOSI: on each sck_rise, shift mosi_s. On the 16th rise -> DONE, and:
    - Write with 1 <= addr < NREGS: reg[addr] <= data. The next cycle has wr_stb_o=1 and wr_addr_o/wr_data_o updated.
    - Write to addr 0: no register change, no strobe.
    - addr >= NREGS, read or write: frame_err_o pulses, no register change.
  - DONE: further SCK edges are ignored and spi_miso_o=0. csn_s rising -> IDLE.
- CSn rise in CMD or DATA (abort):
  - FSM -> IDLE; no write; frame_err_o pulses once.
  - spi_misooen_o=1, spi_miso_o=0, busy_o=0.
- Simultaneous events: csn_s=1 takes precedence over an sck edge in the same cycle. A 16th edge coincident with csn_s rising counts as an abort.
- Leaving DONE normally (csn_s rise) gives no error pulse.
- spi_misooen_o=0 exactly while the FSM is not IDLE.
- A read of a register written in the same frame cannot occur; a read returns the value at the 8th rising edge.
- Register updates from SPI are the only writers; regs_o is registered.

Test Plan:
- Reset, then check outputs: regs_o reg0=0xA5, others 0x00; spi_misooen_o=1; no strobes.
- Write frame 0x8337 (write, addr 3, data 0x37) at SCK = clk/8:
  - regs_o[31:24]=0x37
  - one wr_stb_o pulse with wr_addr_o=3, wr_data_o=0x37
  - frame_err_o stays 0
- After the write, read frame 0x0300 (read, addr 3): MISO bits 7..0 sampled on rises 9..16 = 0x37. Then read addr 0: MISO = 0xA5.
- Write 0x80FF (write, addr 0, data 0xFF): reg0 remains 0xA5, no wr_stb_o. Then write to addr 9 (NREGS=8): frame_err_o pulses, regs unchanged, and a read of addr 9 returns 0x00 with frame_err_o.
- Abort: raise CSn after 11 SCK rises of write 0x8455 -> reg4 unchanged, no wr_stb_o, one frame_err_o pulse, busy_o=0. The next full frame works normally.
- Overlong frame: 20 SCK cycles of write 0x8512 -> reg5=0x12 committed at the 16th rise, extra bits ignored, MISO=0 in DONE. Also assert rstn_i mid-frame -> all outputs immediately return to reset values.

Source files
------------

// File: rtl/mpei_spi_slave_regif.sv
// SPI mode-0 slave giving an external master read/write access to a bank of 8-bit registers.
// SPI pins are oversampled by clk_i; register 0 is a read-only ID.
//
// state | meaning
// IDLE  | CSn high, MISO tri-stated
// CMD   | shifting RW + 7-bit address (rises 1..8)
// DATA  | shifting data in on rises, register data out on falls (rises 9..16)
// DONE  | frame complete, further SCK edges ignored until CSn rises
module mpei_spi_slave_regif #(
    parameter int         NREGS  = 8,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               spi_sck_i,
    input  logic               spi_mosi_i,
    input  logic               spi_csn_i,
    output logic               spi_miso_o,
    output logic               spi_misooen_o,
    output logic [NREGS*8-1:0] regs_o,
    output logic               wr_stb_o,
    output logic [6:0]         wr_addr_o,
    output logic [7:0]         wr_data_o,
    output logic               frame_err_o,
    output logic               busy_o
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t      state_q, state_nx;
    logic [1:0]  sck_sync, mosi_sync, csn_sync;
    logic        sck_q;
    logic        sck_s, mosi_s, csn_s;
    logic        sck_rise, sck_fall;
    logic [3:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  tx_sr;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  regs_q [NREGS];

    logic        shift_rx, latch_cmd, commit, abort, shift_tx;
    logic [7:0]  rx_byte;
    logic [6:0]  cmd_addr;
    logic        cmd_addr_ok, addr_q_ok;

    assign sck_s    = sck_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign csn_s    = csn_sync[1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;

    // Byte as it will look once the current MOSI bit is shifted in.
    assign rx_byte     = {rx_sr, mosi_s};
    assign cmd_addr    = rx_byte[6:0];
    assign cmd_addr_ok = ({1'b0, cmd_addr} < 8'(NREGS));
    assign addr_q_ok   = ({1'b0, addr_q} < 8'(NREGS));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            csn_sync  <= 2'b11;
            sck_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
            csn_sync  <= {csn_sync[0], spi_csn_i};
            sck_q     <= sck_s;
        end
    end

    // CSn high wins over any SCK edge seen in the same cycle.
    always_comb begin
        state_nx  = state_q;
        shift_rx  = 1'b0;
        latch_cmd = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        shift_tx  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!csn_s) state_nx = CMD;
            end
            CMD: begin
                if (csn_s) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else if (sck_rise) begin
                    shift_rx = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        latch_cmd = 1'b1;
                        state_nx  = DATA;
                    end
                end
            end
            DATA: begin
                if (csn_s) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else begin
                    if (sck_rise) begin
                        shift_rx = 1'b1;
                        if (bit_cnt == 4'd15) begin
                            commit   = 1'b1;
                            state_nx = DONE;
                        end
                    end
                    if (sck_fall) shift_tx = 1'b1;
                end
            end
            DONE: begin
                if (csn_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            bit_cnt       <= 4'd0;
            rx_sr         <= 7'd0;
            tx_sr         <= 8'd0;
            rw_q          <= 1'b0;
            addr_q        <= 7'd0;
            spi_miso_o    <= 1'b0;
            spi_misooen_o <= 1'b1;
            wr_stb_o      <= 1'b0;
            wr_addr_o     <= 7'd0;
            wr_data_o     <= 8'd0;
            frame_err_o   <= 1'b0;
            busy_o        <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == 0) ? ID_VAL : 8'h00;
        end else begin
            state_q       <= state_nx;
            wr_stb_o      <= 1'b0;
            frame_err_o   <= 1'b0;
            busy_o        <= ~csn_s;
            spi_misooen_o <= (state_nx == IDLE);

            if (state_q == IDLE) bit_cnt <= 4'd0;

            if (shift_rx) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (latch_cmd) begin
                rw_q   <= rx_byte[7];
                addr_q <= cmd_addr;
                tx_sr  <= cmd_addr_ok ? regs_q[cmd_addr[AW-1:0]] : 8'h00;
            end

            if (shift_tx) begin
                spi_miso_o <= tx_sr[7];
                tx_sr      <= {tx_sr[6:0], 1'b0};
            end
            if (state_nx != DATA) spi_miso_o <= 1'b0;

            if (abort) frame_err_o <= 1'b1;

            if (commit) begin
                if (!addr_q_ok) begin
                    frame_err_o <= 1'b1;
                end else if (rw_q && (addr_q != 7'd0)) begin
                    regs_q[addr_q[AW-1:0]] <= rx_byte;
                    wr_stb_o               <= 1'b1;
                    wr_addr_o              <= addr_q;
                    wr_data_o              <= rx_byte;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_o[8*g +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_mpei_spi_slave_regif.sv
// Directed bench for mpei_spi_slave_regif: bit-banged SPI mode-0 frames at SCK = clk/8.
module tb_mpei_spi_slave_regif;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        csn = 1'b1;
    logic        miso, misooen;
    logic [63:0] regs;
    logic        wr_stb;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int err_cnt  = 0;

    logic [63:0] exp_regs;
    logic [15:0] miso_bits;
    int          stb_base, err_base;

    mpei_spi_slave_regif #(.NREGS(8), .ID_VAL(8'hA5)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .spi_sck_i    (sck),
        .spi_mosi_i   (mosi),
        .spi_csn_i    (csn),
        .spi_miso_o   (miso),
        .spi_misooen_o(misooen),
        .regs_o       (regs),
        .wr_stb_o     (wr_stb),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .frame_err_o  (frame_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb)    stb_cnt++;
        if (frame_err) err_cnt++;
    end

    // Runs one frame of nbits SCK cycles; miso_out holds the last 16 MISO samples taken just before each rise.
    task automatic spi_xfer(input logic [15:0] word, input int nbits, output logic [15:0] miso_out);
        logic b;
        miso_out = 16'h0;
        stb_base = stb_cnt;
        err_base = err_cnt;
        @(negedge clk);
        csn = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (misooen !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_active: misooen=%b busy=%b, required misooen=0 busy=1", misooen, busy);
        end
        for (int i = 0; i < nbits; i++) begin
            b = 1'b0;
            if (i < 16) b = word[15-i];
            mosi = b;
            repeat (4) @(negedge clk);
            miso_out = {miso_out[14:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        repeat (8) @(negedge clk);
        csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        exp_regs = 64'h0000_0000_0000_00A5;
        n_checks++;
        if (regs !== exp_regs) begin
            n_fail++;
            $display("FAIL reset_regs: got %h, required %h", regs, exp_regs);
        end
        n_checks++;
        if ({misooen, miso, wr_stb, frame_err, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: oen,miso,stb,err,busy=%b, required 10000", {misooen, miso, wr_stb, frame_err, busy});
        end
        n_checks++;
        if (wr_addr !== 7'd0 || wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_wr: addr=%h data=%h, required 0 0", wr_addr, wr_data);
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        spi_xfer(16'h8337, 16, miso_bits);
        exp_regs[31:24] = 8'h37;
        n_checks++;
        if (regs !== exp_regs) begin
            n_fail++;
            $display("FAIL write_regs: got %h, required %h", regs, exp_regs);
        end
        n_checks++;
        if (stb_cnt - stb_base != 1 || wr_addr !== 7'd3 || wr_data !== 8'h37) begin
            n_fail++;
            $display("FAIL write_stb: pulses=%0d addr=%h data=%h, required 1 03 37", stb_cnt - stb_base, wr_addr, wr_data);
        end
        n_checks++;
        if (err_cnt != err_base) begin
            n_fail++;
            $display("FAIL write_err: err pulses=%0d, required 0", err_cnt - err_base);
        end
    endtask

    task automatic test_read();
        spi_xfer(16'h0300, 16, miso_bits);
        n_checks++;
        if (miso_bits[7:0] !== 8'h37) begin
            n_fail++;
            $display("FAIL read_addr3: got %h, required 37", miso_bits[7:0]);
        end
        n_checks++;
        if (miso_bits[15:8] !== 8'h00) begin
            n_fail++;
            $display("FAIL read_cmd_miso: got %h, required 00", miso_bits[15:8]);
        end
        spi_xfer(16'h0000, 16, miso_bits);
        n_checks++;
        if (miso_bits[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_addr0: got %h, required a5", miso_bits[7:0]);
        end
        n_checks++;
        if (stb_cnt - stb_base != 0 || err_cnt != err_base) begin
            n_fail++;
            $display("FAIL read_pulses: stb=%0d err=%0d, required 0 0", stb_cnt - stb_base, err_cnt - err_base);
        end
    endtask

    task automatic test_addr0_write();
        spi_xfer(16'h80FF, 16, miso_bits);
        n_checks++;
        if (regs !== exp_regs) begin
            n_fail++;
            $display("FAIL addr0_regs: got %h, required %h", regs, exp_regs);
        end
        n_checks++;
        if (stb_cnt - stb_base != 0 || err_cnt != err_base) begin
            n_fail++;
            $display("FAIL addr0_pulses: stb=%0d err=%0d, required 0 0", stb_cnt - stb_base, err_cnt - err_base);
        end
    endtask

    task automatic test_bad_addr();
        spi_xfer(16'h8977, 16, miso_bits);
        n_checks++;
        if (regs !== exp_regs) begin
            n_fail++;
            $display("FAIL badw_regs: got %h, required %h", regs, exp_regs);
        end
        n_checks++;
        if (stb_cnt - stb_base != 0 || err_cnt - err_base != 1) begin
            n_fail++;
            $display("FAIL badw_pulses: stb=%0d err=%0d, required 0 1", stb_cnt - stb_base, err_cnt - err_base);
        end
        spi_xfer(16'h0900, 16, miso_bits);
        n_checks++;
        if (miso_bits[7:0] !== 8'h00 || err_cnt - err_base != 1) begin
            n_fail++;
            $display("FAIL badr: data=%h err=%0d, required 00 1", miso_bits[7:0], err_cnt - err_base);
        end
    endtask

    task automatic test_abort();
        spi_xfer(16'h8455, 11, miso_bits);
        n_checks++;
        if (regs !== exp_regs) begin
            n_fail++;
            $display("FAIL abort_regs: got %h, required %h", regs, exp_regs);
        end
        n_checks++;
        if (stb_cnt - stb_base != 0 || err_cnt - err_base != 1) begin
            n_fail++;
            $display("FAIL abort_pulses: stb=%0d err=%0d, required 0 1", stb_cnt - stb_base, err_cnt - err_base);
        end
        n_checks++;
        if (busy !== 1'b0 || misooen !== 1'b1 || miso !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b oen=%b miso=%b, required 0 1 0", busy, misooen, miso);
        end
        spi_xfer(16'h8466, 16, miso_bits);
        exp_regs[39:32] = 8'h66;
        n_checks++;
        if (regs !== exp_regs || stb_cnt - stb_base != 1 || wr_addr !== 7'd4) begin
            n_fail++;
            $display("FAIL after_abort: regs=%h stb=%0d addr=%h, required %h 1 04", regs, stb_cnt - stb_base, wr_addr, exp_regs);
        end
    endtask

    task automatic test_overlong();
        spi_xfer(16'h8512, 20, miso_bits);
        exp_regs[47:40] = 8'h12;
        n_checks++;
        if (regs !== exp_regs) begin
            n_fail++;
            $display("FAIL overlong_regs: got %h, required %h", regs, exp_regs);
        end
        n_checks++;
        if (stb_cnt - stb_base != 1 || wr_data !== 8'h12 || err_cnt != err_base) begin
            n_fail++;
            $display("FAIL overlong_pulses: stb=%0d data=%h err=%0d, required 1 12 0", stb_cnt - stb_base, wr_data, err_cnt - err_base);
        end
        n_checks++;
        if (miso_bits[3:0] !== 4'h0) begin
            n_fail++;
            $display("FAIL overlong_done_miso: got %h, required 0", miso_bits[3:0]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w;
        w = 16'h8699;
        @(negedge clk);
        csn = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            mosi = w[15-i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        n_checks++;
        if (misooen !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_oen: got %b, required 0", misooen);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (regs !== 64'h0000_0000_0000_00A5) begin
            n_fail++;
            $display("FAIL midreset_regs: got %h, required 00000000000000a5", regs);
        end
        n_checks++;
        if ({misooen, miso, wr_stb, frame_err, busy} !== 5'b10000 || wr_addr !== 7'd0 || wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: oen,miso,stb,err,busy=%b addr=%h data=%h, required 10000 0 0",
                     {misooen, miso, wr_stb, frame_err, busy}, wr_addr, wr_data);
        end
        csn = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        exp_regs = 64'h0000_0000_0000_00A5;
        spi_xfer(16'h8233, 16, miso_bits);
        exp_regs[23:16] = 8'h33;
        n_checks++;
        if (regs !== exp_regs || stb_cnt - stb_base != 1) begin
            n_fail++;
            $display("FAIL post_reset_write: regs=%h stb=%0d, required %h 1", regs, stb_cnt - stb_base, exp_regs);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr0_write();
        test_bad_addr();
        test_abort();
        test_overlong();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
